// File: rtl/pipe_add_acc.sv
// Two-stage pipelined add/sub/accumulate unit with valid/ready on both sides.
// Stage 1 holds the accepted operands; stage 2 is the registered result.
module pipe_add_acc #(
    parameter int unsigned DATA_W   = 4,
    parameter int unsigned OUT_W    = 8,
    parameter int unsigned SAT_MODE = 0,
    parameter int unsigned CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    input  logic [1:0]        in_op,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OUT_W-1:0]  out_sum,
    output logic              out_ovf,
    output logic [CNT_W-1:0]  txn_cnt,
    output logic              dbg_busy
);

    localparam int unsigned XW = OUT_W + 1;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_ACC = 2'b10,
        OP_CLR = 2'b11
    } op_e;

    logic              s1_valid;
    logic [DATA_W-1:0] s1_a;
    logic [DATA_W-1:0] s1_b;
    op_e               s1_op;
    logic              s2_valid;
    logic [OUT_W-1:0]  acc;

    logic              in_fire;
    logic              out_fire;
    logic              s2_load;

    logic [XW-1:0]     a_x;
    logic [XW-1:0]     b_x;
    logic [XW-1:0]     t;
    logic [OUT_W-1:0]  nxt_sum;
    logic              nxt_ovf;
    logic [OUT_W-1:0]  nxt_acc;

    assign s2_load   = s1_valid && (!s2_valid || out_ready);
    assign in_ready  = !s1_valid || s2_load;
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = s2_valid && out_ready;
    assign out_valid = s2_valid;
    assign dbg_busy  = s1_valid || s2_valid;

    // One extra bit exposes carry (accumulate) or borrow (subtract) in t[OUT_W].
    always_comb begin
        a_x     = XW'(s1_a);
        b_x     = XW'(s1_b);
        t       = '0;
        nxt_sum = '0;
        nxt_ovf = 1'b0;
        nxt_acc = acc;
        case (s1_op)
            OP_ADD: begin
                t       = a_x + b_x;
                nxt_sum = t[OUT_W-1:0];
            end
            OP_SUB: begin
                t       = a_x - b_x;
                nxt_ovf = t[OUT_W];
                nxt_sum = (t[OUT_W] && (SAT_MODE != 0)) ? '0 : t[OUT_W-1:0];
            end
            OP_ACC: begin
                t       = {1'b0, acc} + a_x + b_x;
                nxt_ovf = t[OUT_W];
                nxt_acc = (t[OUT_W] && (SAT_MODE != 0)) ? '1 : t[OUT_W-1:0];
                nxt_sum = nxt_acc;
            end
            OP_CLR: begin
                nxt_acc = '0;
                nxt_sum = '0;
            end
            default: begin
                nxt_acc = acc;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_op    <= OP_ADD;
        end else if (in_fire) begin
            s1_valid <= 1'b1;
            s1_a     <= in_a;
            s1_b     <= in_b;
            s1_op    <= op_e'(in_op);
        end else if (s2_load) begin
            s1_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            out_sum  <= '0;
            out_ovf  <= 1'b0;
            acc      <= '0;
        end else if (s2_load) begin
            s2_valid <= 1'b1;
            out_sum  <= nxt_sum;
            out_ovf  <= nxt_ovf;
            acc      <= nxt_acc;
        end else if (out_fire) begin
            s2_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            txn_cnt <= '0;
        end else if (out_fire) begin
            txn_cnt <= txn_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipe_add_acc.sv
// Directed bench for pipe_add_acc: a wrapping and a saturating instance share
// the same stimulus; expected values are hand-computed constants.
module tb_pipe_add_acc;

    localparam logic [1:0] ADD = 2'b00;
    localparam logic [1:0] SUB = 2'b01;
    localparam logic [1:0] ACC = 2'b10;
    localparam logic [1:0] CLR = 2'b11;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [3:0]  in_a;
    logic [3:0]  in_b;
    logic [1:0]  in_op;
    logic        out_ready;

    logic        rdy_w, ov_w, ovf_w, busy_w;
    logic [7:0]  sum_w;
    logic [15:0] cnt_w;
    logic        rdy_s, ov_s, ovf_s, busy_s;
    logic [7:0]  sum_s;
    logic [15:0] cnt_s;

    int n_run  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    pipe_add_acc #(.DATA_W(4), .OUT_W(8), .SAT_MODE(0), .CNT_W(16)) u_wrap (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_w),
        .in_a(in_a), .in_b(in_b), .in_op(in_op), .out_valid(ov_w),
        .out_ready(out_ready), .out_sum(sum_w), .out_ovf(ovf_w),
        .txn_cnt(cnt_w), .dbg_busy(busy_w)
    );

    pipe_add_acc #(.DATA_W(4), .OUT_W(8), .SAT_MODE(1), .CNT_W(16)) u_sat (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_s),
        .in_a(in_a), .in_b(in_b), .in_op(in_op), .out_valid(ov_s),
        .out_ready(out_ready), .out_sum(sum_s), .out_ovf(ovf_s),
        .txn_cnt(cnt_s), .dbg_busy(busy_s)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        n_run++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Present one operand for a single cycle; both instances must accept it.
    task automatic send(input logic [1:0] op, input int a, input int b);
        in_op    = op;
        in_a     = 4'(a);
        in_b     = 4'(b);
        in_valid = 1'b1;
        @(negedge clk);
        chk("send_rdy", int'({rdy_w, rdy_s}), 3);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Result must be valid exactly one edge after send() returned.
    task automatic res(input string tag, input int ew, input int fw, input int es, input int fs);
        @(posedge clk);
        #1;
        chk({tag, "_vld"},   int'({ov_w, ov_s}), 3);
        chk({tag, "_sum_w"}, int'(sum_w), ew);
        chk({tag, "_ovf_w"}, int'(ovf_w), fw);
        chk({tag, "_sum_s"}, int'(sum_s), es);
        chk({tag, "_ovf_s"}, int'(ovf_s), fs);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        acc_now;
        logic [15:0] cnt0;
        logic [15:0] d;
        int          idx;
        int          nres;
        int          stall;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_op     = ADD;
        out_ready = 1'b1;

        #2;
        chk("rst_vld",  int'({ov_w, ov_s}), 0);
        chk("rst_sum",  int'({sum_w, sum_s}), 0);
        chk("rst_ovf",  int'({ovf_w, ovf_s}), 0);
        chk("rst_cnt",  int'({cnt_w, cnt_s}), 0);
        chk("rst_busy", int'({busy_w, busy_s}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_rdy", int'({rdy_w, rdy_s}), 3);

        // 1: add and latency
        send(ADD, 15, 15);
        chk("t1_lat", int'({ov_w, ov_s}), 0);
        res("t1", 30, 0, 30, 0);

        // 2: subtract with and without borrow
        send(SUB, 3, 5);
        res("t2a", 254, 1, 0, 1);
        send(SUB, 9, 4);
        res("t2b", 5, 0, 5, 0);

        // 3: accumulate up to and past the carry-out
        send(CLR, 7, 7);
        res("t3clr", 0, 0, 0, 0);
        for (int i = 1; i <= 8; i++) begin
            send(ACC, 15, 15);
            res("t3acc", 30 * i, 0, 30 * i, 0);
        end
        send(ACC, 15, 15);
        res("t3ovf", 14, 1, 255, 1);
        send(ADD, 1, 1);
        res("t3add", 2, 0, 2, 0);
        send(ACC, 0, 0);
        res("t3keep", 14, 0, 255, 0);
        @(posedge clk);
        #1;
        chk("t3_cnt", int'(cnt_w), 15);
        chk("t3_cnt_s", int'(cnt_s), 15);

        // 4: backpressure with continuous input
        out_ready = 1'b0;
        in_op     = ADD;
        in_a      = 4'd1;
        in_b      = 4'd1;
        in_valid  = 1'b1;
        idx       = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            acc_now = rdy_w;
            @(posedge clk);
            #1;
            if (acc_now) begin
                idx++;
                in_a = 4'(idx + 1);
                in_b = 4'(idx + 1);
                if (idx == 3) in_valid = 1'b0;
            end
        end
        chk("t4_accepted", idx, 2);
        chk("t4_rdy", int'({rdy_w, rdy_s}), 0);
        chk("t4_vld", int'({ov_w, ov_s}), 3);
        chk("t4_hold", int'(sum_w), 2);
        cnt0      = cnt_w;
        out_ready = 1'b1;
        nres      = 0;
        for (int k = 0; k < 10 && nres < 3; k++) begin
            @(negedge clk);
            if (ov_w) begin
                chk("t4_order_w", int'(sum_w), 2 * (nres + 1));
                chk("t4_order_s", int'(sum_s), 2 * (nres + 1));
                nres++;
            end
            acc_now = in_valid && rdy_w;
            @(posedge clk);
            #1;
            if (acc_now) begin
                idx++;
                in_a = 4'(idx + 1);
                in_b = 4'(idx + 1);
                if (idx == 3) in_valid = 1'b0;
            end
        end
        in_valid = 1'b0;
        chk("t4_nres", nres, 3);
        d = cnt_w - cnt0;
        chk("t4_cnt", int'(d), 3);

        // 5: 20 back-to-back adds at full throughput
        cnt0  = cnt_w;
        nres  = 0;
        stall = 0;
        for (int k = 0; k < 23; k++) begin
            if (k < 20) begin
                in_valid = 1'b1;
                in_op    = ADD;
                in_a     = 4'(k);
                in_b     = 4'(k * 3);
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            if (k < 20 && !rdy_w) stall++;
            if (ov_w) begin
                chk("t5_sum", int'(sum_w), (nres % 16) + ((nres * 3) % 16));
                chk("t5_slot", k, nres + 2);
                nres++;
            end
            if (k == 21) chk("t5_busy_hi", int'({busy_w, busy_s}), 3);
            if (k == 22) chk("t5_busy_lo", int'({busy_w, busy_s}), 0);
            @(posedge clk);
            #1;
        end
        chk("t5_stall", stall, 0);
        chk("t5_nres", nres, 20);
        d = cnt_w - cnt0;
        chk("t5_cnt", int'(d), 20);

        // 6: asynchronous reset with two transactions in flight, acc=100
        send(CLR, 0, 0);
        res("t6clr", 0, 0, 0, 0);
        for (int i = 1; i <= 3; i++) begin
            send(ACC, 15, 15);
            res("t6acc", 30 * i, 0, 30 * i, 0);
        end
        send(ACC, 5, 5);
        res("t6acc100", 100, 0, 100, 0);
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        in_op     = ADD;
        in_a      = 4'd1;
        in_b      = 4'd1;
        in_valid  = 1'b1;
        @(posedge clk);
        #1;
        in_a = 4'd2;
        in_b = 4'd2;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("t6_busy", int'({busy_w, busy_s}), 3);
        chk("t6_vld", int'({ov_w, ov_s}), 3);
        #3;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_vld",  int'({ov_w, ov_s}), 0);
        chk("t6_rst_sum",  int'({sum_w, sum_s}), 0);
        chk("t6_rst_ovf",  int'({ovf_w, ovf_s}), 0);
        chk("t6_rst_cnt",  int'({cnt_w, cnt_s}), 0);
        chk("t6_rst_busy", int'({busy_w, busy_s}), 0);
        @(posedge clk);
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("t6_rdy", int'({rdy_w, rdy_s}), 3);
        chk("t6_nostale", int'({ov_w, ov_s}), 0);
        send(ACC, 1, 1);
        res("t6post", 2, 0, 2, 0);
        @(posedge clk);
        #1;
        chk("t6_cnt", int'(cnt_w), 1);
        chk("t6_idle", int'({ov_w, ov_s}), 0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_add_acc.md
Name: pipe_add_acc

Overview:
Parametrised, two-stage pipelined adder/accumulator with valid/ready handshakes on both sides. It is the next-generation replacement for the team's single-register a+b adder. New capabilities over that adder:
- selectable add, subtract, accumulate and clear operations
- wrap or saturate overflow policy
- backpressure support
- an output transaction counter for debug

It sits between an operand producer and a result consumer in the datapath.

Parameters:
DATA_W, 4, operand width (>=1)
OUT_W, 8, result and accumulator width; must satisfy OUT_W >= DATA_W+1
SAT_MODE, 0, 0 = wrap on overflow/borrow, 1 = saturate
CNT_W, 16, width of the transaction counter

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  reset, asynchronous, active-low
in_valid  in  1  operand/op present
in_ready  out  1  block accepts operand this cycle
in_a  in  DATA_W  operand A, unsigned
in_b  in  DATA_W  operand B, unsigned
in_op  in  2  00 add, 01 sub, 10 accumulate, 11 clear accumulator
out_valid  out  1  result present
out_ready  in  1  consumer accepts result
out_sum  out  OUT_W  result
out_ovf  out  1  overflow/borrow flag for this result
txn_cnt  out  CNT_W  count of completed output handshakes
dbg_busy  out  1  any pipeline stage holds a transaction

Behaviour:
Reset (rst_n low, asynchronous):
- s1_valid, s2_valid, out_valid = 0
- out_sum = 0, out_ovf = 0, accumulator = 0, txn_cnt = 0
- in_ready = 1 after reset releases

Handshake and pipeline control:
- Input accepted when in_valid && in_ready; output consumed when out_valid && out_ready.
- s2_load = s1_valid && (!s2_valid || out_ready)
- in_ready = !s1_valid || s2_load (combinational from out_ready; no combinational path from in_valid)
- Stage 1 registers a, b, op on input accept. Stage 2 computes the result and registers it on s2_load.
- Latency: accept at edge N -> out_valid high after edge N+1. Throughput: 1 per cycle when out_ready stays high.

Ordering and stability:
- out_sum/out_ovf stay stable while out_valid && !out_ready.
- out_sum holds its last value after the result is consumed.
- No transaction is dropped or duplicated under any backpressure pattern.
- Results emerge in strict input order.

Operations (evaluated at s2_load, width OUT_W+1 internally):
- add: out_sum = zero-extended a+b; out_ovf = 0 (cannot overflow by parameter rule).
- sub: if a >= b, out_sum = a-b, out_ovf = 0.
  - If a < b and SAT_MODE = 0: out_sum = two's-complement a-b mod 2^OUT_W, out_ovf = 1.
  - If a < b and SAT_MODE = 1: out_sum = 0, out_ovf = 1.
- accumulate: t = acc + a + b.
  - No carry out of OUT_W bits: acc <= t, out_ovf = 0.
  - Carry out and SAT_MODE = 0: acc <= t mod 2^OUT_W, out_ovf = 1.
  - Carry out and SAT_MODE = 1: acc <= all-ones, out_ovf = 1.
  - In every case out_sum = the new acc value.
- clear: acc <= 0, out_sum = 0, out_ovf = 0; operands ignored.
- add/sub leave the accumulator unchanged.
- Accumulator updates only on s2_load, so back-to-back accumulates chain correctly with no hazard.

Other outputs:
- txn_cnt increments by 1 on each output handshake and wraps at 2^CNT_W.
- dbg_busy = s1_valid || s2_valid.

Reset mid-operation: all in-flight transactions are discarded and the accumulator is cleared. Nothing is replayed after reset.

Test Plan:
1. DATA_W=4, OUT_W=8, out_ready=1; add a=15, b=15 accepted at edge N -> out_valid after edge N+1, out_sum=30, out_ovf=0.
2. sub a=3, b=5 -> SAT_MODE=0: out_sum=0xFE, out_ovf=1; SAT_MODE=1: out_sum=0x00, out_ovf=1. sub a=9, b=4 -> 5, ovf 0.
3. clear, then 9 accumulates of a=15, b=15:
   - Results 30, 60, ..., 240, all with ovf 0.
   - 9th result: SAT_MODE=0 gives out_sum=14, ovf 1; SAT_MODE=1 gives out_sum=255, ovf 1.
   - A following add 1+1 returns 2 and leaves acc unchanged.
4. out_ready=0 for 6 cycles while in_valid=1 with ops add 1+1, 2+2, 3+3:
   - Exactly 2 accepted, then in_ready=0; out_sum holds 2.
   - After out_ready=1: results 2, 4, 6 in order; txn_cnt increases by 3.
5. 20 back-to-back adds with out_ready=1 -> one result per cycle after the 2-cycle fill; txn_cnt=20; dbg_busy drops 2 cycles after the last accept.
6. Assert rst_n low asynchronously mid-clock with 2 transactions in flight and acc=100:
   - Outputs go to reset values immediately, without waiting for a clock edge.
   - After release, accumulate 1+1 returns 2 and no stale result appears.
